// File: rtl/hazard_flush_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : hazard_flush_ctrl_pkg
// Brief  : Shared types for the 5-stage core hazard / flush controller.
// Rev    : 1.0  initial release
// ============================================================================
package hazard_flush_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_RUN        = 2'd0,
        HZ_LOAD_STALL = 2'd1,
        HZ_MEM_WAIT   = 2'd2,
        HZ_FLUSH      = 2'd3
    } hazard_state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // Wide enough for the largest allowed MAX_MEM_WAIT (255).
    localparam int c_WAIT_W = 8;

endpackage
`default_nettype wire

// File: rtl/hazard_flush_ctrl_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module : fwd_unit
// Brief  : Combinational EX operand forwarding select for one source register.
// Rev    : 1.0  initial release
// ============================================================================
module fwd_unit
    import hazard_flush_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_wr,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_wr,
    output fwd_sel_t         sel
);

    logic w_mem_hit;
    logic w_wb_hit;

    // x0 is hardwired zero, so a write to it never forwards.
    assign w_mem_hit = mem_wr && (mem_rd != '0) && (mem_rd == ex_rs);
    assign w_wb_hit  = wb_wr  && (wb_rd  != '0) && (wb_rd  == ex_rs);

    always_comb begin
        sel = FWD_RF;
        if (w_mem_hit) begin
            sel = FWD_MEM;
        end else if (w_wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module : hazard_flush_ctrl
// Brief  : Pipeline enables, registered flush pulses and forwarding selects.
// Rev    : 1.0  initial release
// ============================================================================
module hazard_flush_ctrl
    import hazard_flush_ctrl_pkg::*;
#(
    parameter int REG_W        = 5,
    parameter int MAX_MEM_WAIT = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] ex_rs1,
    input  logic [REG_W-1:0] ex_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_d_rd,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_wr,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_wr,
    input  logic             br_taken,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MAX_MEM_WAIT - 1);

    hazard_state_t       r_state;
    logic                r_ifid_flush;
    logic                r_idex_flush;
    logic                r_mem_timeout;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;
    logic [c_WAIT_W-1:0] r_wait_cnt;

    hazard_state_t w_next_state;
    logic          w_mem_hold;
    logic          w_load_use;
    logic          w_front_en;
    logic          w_back_en;
    logic          w_do_flush;
    logic          w_do_bubble;
    logic          w_timeout;
    fwd_sel_t      w_fwd_a;
    fwd_sel_t      w_fwd_b;

    assign w_mem_hold = dmem_req & ~dmem_ack;
    assign w_load_use = ex_d_rd && (ex_rd != '0) &&
                        ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    always_comb begin
        w_next_state = r_state;
        w_front_en   = 1'b1;
        w_back_en    = 1'b1;
        w_do_flush   = 1'b0;
        w_do_bubble  = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            HZ_MEM_WAIT: begin
                if (dmem_ack) begin
                    // Stages were frozen, so the held branch/load-use is re-judged now.
                    if (br_taken) begin
                        w_do_flush   = 1'b1;
                        w_next_state = HZ_FLUSH;
                    end else if (w_load_use) begin
                        w_front_en   = 1'b0;
                        w_do_bubble  = 1'b1;
                        w_next_state = HZ_LOAD_STALL;
                    end else begin
                        w_next_state = HZ_RUN;
                    end
                end else begin
                    w_front_en = 1'b0;
                    w_back_en  = 1'b0;
                    if (r_wait_cnt == c_WAIT_LAST) begin
                        w_timeout    = 1'b1;
                        w_next_state = HZ_RUN;
                    end
                end
            end
            default: begin
                if (w_mem_hold) begin
                    w_front_en   = 1'b0;
                    w_back_en    = 1'b0;
                    w_next_state = HZ_MEM_WAIT;
                end else if (br_taken && (r_state != HZ_FLUSH)) begin
                    w_do_flush   = 1'b1;
                    w_next_state = HZ_FLUSH;
                end else if (w_load_use && (r_state == HZ_RUN)) begin
                    w_front_en   = 1'b0;
                    w_do_bubble  = 1'b1;
                    w_next_state = HZ_LOAD_STALL;
                end else begin
                    w_next_state = HZ_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= HZ_RUN;
            r_ifid_flush  <= 1'b0;
            r_idex_flush  <= 1'b0;
            r_mem_timeout <= 1'b0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
            r_wait_cnt    <= '0;
        end else begin
            r_state      <= w_next_state;
            r_ifid_flush <= w_do_flush;
            r_idex_flush <= w_do_flush | w_do_bubble;
            if ((r_state == HZ_MEM_WAIT) && (w_next_state == HZ_MEM_WAIT)) begin
                r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_timeout) begin
                r_mem_timeout <= 1'b1;
            end
            if (!w_front_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_do_flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    fwd_unit #(.REG_W(REG_W)) u_fwd_a (
        .ex_rs  (ex_rs1),
        .mem_rd (mem_rd),
        .mem_wr (mem_wr),
        .wb_rd  (wb_rd),
        .wb_wr  (wb_wr),
        .sel    (w_fwd_a)
    );

    fwd_unit #(.REG_W(REG_W)) u_fwd_b (
        .ex_rs  (ex_rs2),
        .mem_rd (mem_rd),
        .mem_wr (mem_wr),
        .wb_rd  (wb_rd),
        .wb_wr  (wb_wr),
        .sel    (w_fwd_b)
    );

    assign pc_en       = w_front_en;
    assign ifid_en     = w_front_en;
    assign idex_en     = w_back_en;
    assign exmem_en    = w_back_en;
    assign ifid_flush  = r_ifid_flush;
    assign idex_flush  = r_idex_flush;
    assign fwd_a       = w_fwd_a;
    assign fwd_b       = w_fwd_b;
    assign mem_timeout = r_mem_timeout;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire
